// File: rtl/seg_pkg.sv
// Shared constants and types for the scanned seven-segment capture block:
// digit count, segment codes for 0-9, and the output-stage state type.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_IDX_W  = $clog2(NUM_DIGITS);

    // Active-high segment codes, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    typedef logic [DIG_IDX_W-1:0] dig_idx_t;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    // Position of the set bit; only meaningful when the select is one-hot.
    function automatic dig_idx_t onehot_index(input logic [NUM_DIGITS-1:0] sel);
        dig_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) idx = dig_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_code_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder; unknown patterns
// produce 4'hF with the invalid flag raised.
module seg_code_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       invalid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        bcd     = 4'hF;
        invalid = 1'b0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit BCD frame from a multiplexed seven-segment scan bus:
// input register, stability filter, per-digit capture buffer, output handshake.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [7:0]       DP_MASK  = 8'h7F;

    logic [7:0]              seg_q, prev_seg;
    logic [NUM_DIGITS-1:0]   dig_q, prev_dig;
    logic [7:0]              seg_m;
    logic [CNT_W-1:0]        cnt;
    logic                    stable, capture, frame_load;
    dig_idx_t                cap_idx;
    logic [3:0]              dec_bcd;
    logic                    dec_err;
    logic [4*NUM_DIGITS-1:0] buf_bcd;
    logic [NUM_DIGITS-1:0]   buf_err, seen, seen_next;
    out_state_e              state, state_next;

    // The decimal point never takes part in comparison or decoding.
    assign seg_m   = seg_q & DP_MASK;
    assign stable  = (seg_m == prev_seg) && (dig_q == prev_dig) && ($countones(dig_q) == 1);
    assign capture = stable && (cnt == CNT_ARM);
    assign cap_idx = onehot_index(dig_q);

    seg_code_to_bcd u_dec (
        .seg     (seg_m[6:0]),
        .bcd     (dec_bcd),
        .invalid (dec_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= '0;
            dig_q    <= '0;
            prev_seg <= '0;
            prev_dig <= '0;
            cnt      <= '0;
        end else begin
            seg_q    <= seg;
            dig_q    <= dig_sel;
            prev_seg <= seg_m;
            prev_dig <= dig_q;
            if (!stable)
                cnt <= '0;
            else if (cnt != CNT_LAST)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // A full seen mask triggers the frame load one edge after the last capture.
    assign frame_load = (seen == '1);

    always_comb begin
        seen_next = frame_load ? '0 : seen;
        if (capture) seen_next = seen_next | dig_q;
    end

    // NOTE: the capture buffer is reset explicitly so a partial frame can never leak across reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_bcd <= '0;
            buf_err <= '0;
            seen    <= '0;
        end else begin
            seen <= seen_next;
            if (capture) begin
                buf_bcd[{cap_idx, 2'b00} +: 4] <= dec_bcd;
                buf_err[cap_idx]               <= dec_err;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OUT_EMPTY: if (frame_load) state_next = OUT_FULL;
            OUT_FULL:  if (out_ready && !frame_load) state_next = OUT_EMPTY;
            default:   state_next = OUT_EMPTY;
        endcase
    end

    assign out_valid = (state == OUT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OUT_EMPTY;
            bcd_out <= '0;
            err_out <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            overrun <= frame_load && (state == OUT_FULL) && !out_ready;
            if (frame_load) begin
                bcd_out <= buf_bcd;
                err_out <= buf_err;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected frames are queued as digits
// are scanned and compared whenever the DUT hands a frame over.
module tb_seg_scan_decoder;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg = 8'h00;
    logic [3:0]  dig_sel = 4'h0;
    logic        out_ready = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        out_valid;
    logic        overrun;

    frame_t exp_q[$];
    int     check_cnt = 0;
    int     pass_cnt = 0;
    int     valid_cycles = 0;
    int     overrun_cycles = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    // Frame monitor: sampled on the falling edge, pops one expectation per handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) valid_cycles++;
            if (overrun) overrun_cycles++;
            if (out_valid && out_ready) begin
                frame_t e;
                check_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL frame_unexpected: got bcd=%h err=%b, no frame expected", bcd_out, err_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({bcd_out, err_out} !== e)
                        $display("FAIL frame_data: got bcd=%h err=%b, expected bcd=%h err=%b",
                                 bcd_out, err_out, e.bcd, e.err);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int d, input logic [7:0] code, input int n);
        seg     = code;
        dig_sel = 4'(1 << d);
        repeat (n) tick();
    endtask

    task automatic blank(input logic [3:0] ds, input int n);
        seg     = 8'h5B;
        dig_sel = ds;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        seg     = 8'h00;
        dig_sel = 4'h0;
        repeat (n) tick();
    endtask

    task automatic drain(input int budget, output bit ok);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_cnt++;
        if ({bcd_out, err_out} !== 20'h0)
            $display("FAIL reset_data: got bcd=%h err=%b, expected 0", bcd_out, err_out);
        else pass_cnt++;
        check_cnt++;
        if ({out_valid, overrun} !== 2'b00)
            $display("FAIL reset_flags: got valid=%b overrun=%b, expected 0 0", out_valid, overrun);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int v0;
        bit ok;
        out_ready = 1'b1;
        v0 = valid_cycles;
        exp_q.push_back('{bcd: 16'h0123, err: 4'h0});
        hold(0, 8'h4F, 8);
        hold(1, 8'h5B, 8);
        hold(2, 8'h06, 8);
        hold(3, 8'h3F, 8);
        idle(4);
        drain(50, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL basic_timeout: frame still pending, expected delivered");
        else pass_cnt++;
        check_cnt++;
        if (valid_cycles - v0 !== 1)
            $display("FAIL basic_valid_len: got %0d valid cycles, expected 1", valid_cycles - v0);
        else pass_cnt++;
    endtask

    task automatic test_short_hold();
        int v0;
        bit ok;
        out_ready = 1'b1;
        v0 = valid_cycles;
        hold(0, 8'h66, 8);
        hold(1, 8'h6D, 8);
        hold(2, 8'h7D, 3);
        hold(3, 8'h07, 8);
        idle(8);
        check_cnt++;
        if (valid_cycles - v0 !== 0)
            $display("FAIL short_no_frame: got %0d valid cycles, expected 0", valid_cycles - v0);
        else pass_cnt++;
        exp_q.push_back('{bcd: 16'h7654, err: 4'h0});
        hold(2, 8'h7D, 4);
        idle(6);
        drain(50, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL short_timeout: frame still pending, expected delivered");
        else pass_cnt++;
        check_cnt++;
        if (valid_cycles - v0 !== 1)
            $display("FAIL short_frame: got %0d valid cycles, expected 1", valid_cycles - v0);
        else pass_cnt++;
    endtask

    task automatic test_error_and_dp();
        bit ok;
        out_ready = 1'b1;
        exp_q.push_back('{bcd: 16'h98F0, err: 4'b0010});
        hold(0, 8'hBF, 8);
        hold(1, 8'h49, 8);
        hold(2, 8'h7F, 8);
        hold(3, 8'h6F, 8);
        idle(4);
        drain(50, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL error_timeout: frame still pending, expected delivered");
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({bcd_out, err_out} !== {16'h98F0, 4'b0010})
            $display("FAIL empty_hold: got bcd=%h err=%b, expected bcd=98f0 err=0010", bcd_out, err_out);
        else pass_cnt++;
    endtask

    task automatic test_blanking();
        int v0;
        bit ok;
        out_ready = 1'b1;
        v0 = valid_cycles;
        hold(0, 8'h3F, 8);
        hold(1, 8'h06, 8);
        blank(4'b0011, 10);
        blank(4'b0000, 10);
        check_cnt++;
        if (valid_cycles - v0 !== 0)
            $display("FAIL blank_no_frame: got %0d valid cycles, expected 0", valid_cycles - v0);
        else pass_cnt++;
        exp_q.push_back('{bcd: 16'h3210, err: 4'h0});
        hold(2, 8'h5B, 8);
        hold(3, 8'h4F, 8);
        idle(4);
        drain(50, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL blank_timeout: frame still pending, expected delivered");
        else pass_cnt++;
        check_cnt++;
        if (valid_cycles - v0 !== 1)
            $display("FAIL blank_frame: got %0d valid cycles, expected 1", valid_cycles - v0);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int o0;
        bit ok;
        out_ready = 1'b0;
        o0 = overrun_cycles;
        hold(0, 8'h3F, 8);
        hold(1, 8'h06, 8);
        hold(2, 8'h5B, 8);
        hold(3, 8'h4F, 8);
        idle(2);
        check_cnt++;
        if ({out_valid, bcd_out} !== {1'b1, 16'h3210})
            $display("FAIL ovr_first_held: got valid=%b bcd=%h, expected 1 3210", out_valid, bcd_out);
        else pass_cnt++;
        exp_q.push_back('{bcd: 16'h5498, err: 4'h0});
        hold(0, 8'h7F, 8);
        hold(1, 8'h6F, 8);
        hold(2, 8'h66, 8);
        hold(3, 8'h6D, 8);
        idle(4);
        check_cnt++;
        if (overrun_cycles - o0 !== 1)
            $display("FAIL ovr_pulse: got %0d overrun cycles, expected 1", overrun_cycles - o0);
        else pass_cnt++;
        check_cnt++;
        if (bcd_out !== 16'h5498)
            $display("FAIL ovr_second: got bcd=%h, expected 5498", bcd_out);
        else pass_cnt++;
        idle(5);
        check_cnt++;
        if (out_valid !== 1'b1)
            $display("FAIL ovr_valid_hold: got valid=%b, expected 1", out_valid);
        else pass_cnt++;
        out_ready = 1'b1;
        drain(20, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL ovr_timeout: frame still pending, expected delivered");
        else pass_cnt++;
        tick();
        check_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL ovr_release: got valid=%b, expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int v0;
        bit ok;
        out_ready = 1'b1;
        hold(0, 8'h06, 8);
        hold(1, 8'h5B, 8);
        hold(2, 8'h4F, 8);
        #2;
        rst_n   = 1'b0;
        seg     = 8'h00;
        dig_sel = 4'h0;
        #1;
        check_cnt++;
        if ({bcd_out, err_out, out_valid, overrun} !== 22'h0)
            $display("FAIL midreset_clear: got bcd=%h err=%b valid=%b overrun=%b, expected all 0",
                     bcd_out, err_out, out_valid, overrun);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        v0 = valid_cycles;
        hold(3, 8'h3F, 8);
        idle(8);
        check_cnt++;
        if (valid_cycles - v0 !== 0)
            $display("FAIL midreset_partial: got %0d valid cycles, expected 0", valid_cycles - v0);
        else pass_cnt++;
        exp_q.push_back('{bcd: 16'h0321, err: 4'h0});
        hold(0, 8'h06, 8);
        hold(1, 8'h5B, 8);
        hold(2, 8'h4F, 8);
        idle(4);
        drain(50, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL midreset_timeout: frame still pending, expected delivered");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_hold();
        test_error_and_dp();
        test_blanking();
        test_overrun();
        test_reset_mid();
        idle(4);
        check_cnt++;
        if (exp_q.size() !== 0)
            $display("FAIL scoreboard_left: got %0d pending frames, expected 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, min 2: consecutive identical cycles required before a digit is captured.
REQ-002 SHALL have port clk  input  1  the single clock; all state on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port seg  input  8  scanned segment bus, active-high; bit0=a … bit6=g, bit7=decimal point.
REQ-005 SHALL have port dig_sel  input  4  digit enable, active-high, one-hot when valid; bit i selects digit i.
REQ-006 SHALL have port bcd_out  output  16  captured frame; digit i at bits [4i+3:4i].
REQ-007 SHALL have port err_out  output  4  bit i set = digit i held an unrecognised segment code.
REQ-008 SHALL have port out_valid  output  1  frame available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts frame.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: an unaccepted frame was overwritten.

Function
REQ-011 SHALL register seg and dig_sel once (input stage); every later rule uses the registered values, latency input->capture = STABLE_CYCLES+1 cycles.
REQ-012 SHALL mask seg bit7 (decimal point) before comparison and decoding.
REQ-013 SHALL decode seg[6:0]: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9; any other code -> 4'hF with error flag.
REQ-014 SHALL keep a saturating stability counter, cleared when registered {seg[6:0],dig_sel} differs from the previous cycle or dig_sel is not exactly one-hot, else incremented.
REQ-015 SHALL issue exactly one capture per stable window, in the cycle the counter reaches STABLE_CYCLES-1; no further capture until the counter is cleared.
REQ-016 SHALL on capture write the decoded value and error flag into slot i of a working buffer and set bit i of a 4-bit seen mask; re-capture of a seen slot overwrites it without a mask change.
REQ-017 SHALL treat dig_sel == 0 or multi-hot as blanking: counter cleared, no capture, buffer untouched.
REQ-018 SHALL, in the cycle the seen mask becomes 4'hF, load bcd_out/err_out from the buffer next edge, clear the seen mask, and assert out_valid.
REQ-019 SHALL run a 2-state output FSM: EMPTY (out_valid=0) -> FULL on frame load; FULL -> EMPTY when out_valid && out_ready, unless a frame loads the same cycle (stay FULL, new data).
REQ-020 SHALL hold bcd_out/err_out stable while FULL and not accepted.
REQ-021 SHALL, if a frame loads in FULL while out_ready=0, overwrite bcd_out/err_out and pulse overrun for one cycle.
REQ-022 SHALL keep bcd_out/err_out at their last value in EMPTY.

Reset
REQ-023 SHALL on rst_n=0, asynchronously clear input registers, stability counter, seen mask, buffer, bcd_out=16'h0000, err_out=4'h0, out_valid=0, overrun=0, FSM=EMPTY.
REQ-024 SHALL discard a partially assembled frame on reset mid-operation; first frame after reset requires all four digits freshly captured.

Structure
REQ-025 SHALL place NUM_DIGITS=4, the ten segment-code constants and the output FSM state type in shared package seg_pkg.
REQ-026 SHALL implement decoding in one combinational sub-module seg_code_to_bcd (seg[6:0] in; bcd[3:0], invalid out).

Verification
REQ-027 SHALL cover: scan digits 0..3 with codes 4F,5B,06,3F, each held 8 cycles, out_ready=1 -> one frame bcd_out=16'h0123, err_out=0, out_valid one cycle.
REQ-028 SHALL cover: digit 2 held 3 cycles only with STABLE_CYCLES=4 -> no capture, no frame until digit 2 held >=4 cycles.
REQ-029 SHALL cover: digit 1 code 0x49 -> frame nibble 1 = F, err_out=4'b0010; seg=0xBF (dp set) decodes as 0.
REQ-030 SHALL cover: out_ready=0, two full frames scanned -> overrun pulses once, bcd_out shows second frame, out_valid stays 1 until out_ready=1.
REQ-031 SHALL cover: dig_sel=4'b0011 or 4'b0000 for 10 cycles -> no capture, seen mask unchanged.
REQ-032 SHALL cover: rst_n low after three digits captured -> all outputs zero immediately; next frame needs all four digits.
